// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer that owns the HI/LO pair.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
// clock over ITER cycles. MTHI/MTLO write HI/LO directly. A divide by zero
// completes at once (lo = all ones, hi = dividend) without entering RUN.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - request strobe, only looked at while idle
//   op     - 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO
//   dataA  - rs operand (multiplicand / dividend / MT source)
//   dataB  - rt operand (multiplier / divisor)
//   flush  - abort the operation in flight; drops a start seen while idle
//   busy   - high while a mul/div is iterating
//   done   - one-cycle pulse when a mul/div result lands in hi/lo
//   hi, lo - HI/LO architectural registers
module muldiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [4:0] LAST     = 5'(ITER - 1);

  state_t      state, state_n;
  logic [4:0]  counter, counter_n;
  logic [63:0] prod, prod_n;
  logic [31:0] opnd, opnd_n;
  logic        is_div, is_div_n;
  logic        neg_lo, neg_lo_n;
  logic        neg_hi, neg_hi_n;
  logic        busy_n, done_n;
  logic [31:0] hi_n, lo_n;

  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_step;
  logic [63:0] step;
  logic [63:0] mul_res;
  logic [31:0] commit_hi, commit_lo;

  // Datapath for one iteration. prod holds {accumulator, multiplier} for a
  // multiply and {partial remainder, dividend/quotient} for a divide, so both
  // operations shift the same 64-bit register; opnd is the multiplicand or
  // divisor magnitude.
  always_comb begin
    abs_a = (op[0] && dataA[31]) ? -dataA : dataA;
    abs_b = (op[0] && dataB[31]) ? -dataB : dataB;

    mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
    mul_step = {mul_sum, prod[31:1]};

    // A clear bit 32 of the 33-bit difference means the divisor fit,
    // so the quotient bit is 1 and the difference becomes the remainder.
    div_shift = {prod[63:32], prod[31]};
    div_diff  = div_shift - {1'b0, opnd};
    div_step  = div_diff[32] ? {div_shift[31:0], prod[30:0], 1'b0}
                             : {div_diff[31:0],  prod[30:0], 1'b1};

    step = is_div ? div_step : mul_step;

    // Sign fix-up on the final iteration's value. The quotient and
    // remainder carry separate sign flags.
    mul_res   = neg_lo ? -step : step;
    commit_hi = is_div ? (neg_hi ? -step[63:32] : step[63:32]) : mul_res[63:32];
    commit_lo = is_div ? (neg_lo ? -step[31:0]  : step[31:0])  : mul_res[31:0];
  end

  // Next-state and output logic.
  always_comb begin
    state_n   = state;
    counter_n = counter;
    prod_n    = prod;
    opnd_n    = opnd;
    is_div_n  = is_div;
    neg_lo_n  = neg_lo;
    neg_hi_n  = neg_hi;
    busy_n    = busy;
    done_n    = 1'b0;
    hi_n      = hi;
    lo_n      = lo;

    case (state)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
              if (op[1] && dataB == 32'd0) begin
                lo_n   = 32'hFFFF_FFFF;
                hi_n   = dataA;
                done_n = 1'b1;
              end else begin
                state_n   = RUN;
                busy_n    = 1'b1;
                counter_n = 5'd0;
                is_div_n  = op[1];
                prod_n    = {32'd0, op[1] ? abs_a : abs_b};
                opnd_n    = op[1] ? abs_b : abs_a;
                neg_lo_n  = op[0] & (dataA[31] ^ dataB[31]);
                neg_hi_n  = op[1] ? (op[0] & dataA[31])
                                  : (op[0] & (dataA[31] ^ dataB[31]));
              end
            end
            OP_MTHI: hi_n = dataA;
            OP_MTLO: lo_n = dataA;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_n   = IDLE;
          busy_n    = 1'b0;
          counter_n = 5'd0;
        end else begin
          prod_n    = step;
          counter_n = counter + 5'd1;
          if (counter == LAST) begin
            state_n   = IDLE;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            counter_n = 5'd0;
            hi_n      = commit_hi;
            lo_n      = commit_lo;
          end
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= 5'd0;
      prod    <= 64'd0;
      opnd    <= 32'd0;
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state   <= state_n;
      counter <= counter_n;
      prod    <= prod_n;
      opnd    <= opnd_n;
      is_div  <= is_div_n;
      neg_lo  <= neg_lo_n;
      neg_hi  <= neg_hi_n;
      busy    <= busy_n;
      done    <= done_n;
      hi      <= hi_n;
      lo      <= lo_n;
    end
  end

endmodule
